l2_cache_control: RTL and testbench
===================================

Name: l2_cache_control

Overview:
- Control FSM that sequences the 4-way, 8-set, 32-byte-line L2 cache datapath.
- Serves one request at a time from the L2 arbiter (128-bit half-line transfers), handles dirty writeback and line fill over the 256-bit physical memory port, and performs next-line prefetch (address+32) after each demand miss.
- Sits between the L2 arbiter, the L2 datapath and physical memory; it contains no data storage, only state.

Parameters:
- PREFETCH_EN, 1, when 1 a demand miss is followed by a next-line prefetch; when 0 the PF_* states are unreachable.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- l2arb_mem_read  in  1  read request from arbiter
- l2arb_mem_write  in  1  write request from arbiter
- l2arb_mem_resp  out  1  single-cycle completion pulse to arbiter
- pmem_read  out  1  physical memory line read
- pmem_write  out  1  physical memory line write
- pmem_resp  in  1  physical memory completion
- hit, dirty  in  1 each  datapath status (dirty is the dirty bit of the replace way)
- hit_num, replace  in  2 each  hit way, LRU victim way
- wr_va0..3, wr_ta0..3, wr_da0..3, wr_dba0..3  out  1 each  per-way array write enables
- wr_lru, wr_prefreg, dba_in  out  1 each  LRU write, prefetch-base load, dirty bit value
- prefmux_sel, din_sel, addrmux_sel  out  1 each  0 = demand address / pmem_rdata / request address; 1 = prefreg+32 / merged line / victim tag address
- dout_sel  out  2  data-out way select

Behaviour:
- Array reads are combinational and writes are clocked, so tag compare is completed in the same cycle as the lookup.
- Reset: state=IDLE, miss_flag=0. All outputs are 0 in IDLE, which is the default for every output in every state unless listed below.
- IDLE: if l2arb_mem_read or l2arb_mem_write, go to CHECK.
- CHECK (prefmux_sel=0):
  - Hit, read: l2arb_mem_resp=1, wr_lru=1, wr_prefreg=1, dout_sel=hit_num.
  - Hit, write: same as hit read, plus din_sel=1, wr_da[hit_num]=1, wr_dba[hit_num]=1, dba_in=1.
  - Next state after a hit: PF_CHECK if PREFETCH_EN and miss_flag, else IDLE. miss_flag is cleared.
  - Miss: set miss_flag; go to WB if dirty, else FILL.
  - Hit latency: 2 cycles from request to l2arb_mem_resp.
- WB: addrmux_sel=1, dout_sel=replace, pmem_write=1; on pmem_resp go to FILL.
- FILL: addrmux_sel=0, din_sel=0, pmem_read=1. On pmem_resp, pulse wr_da/wr_ta/wr_va/wr_dba[replace] with dba_in=0, then go to CHECK, which now hits.
- PF_CHECK (prefmux_sel=1 in all PF_* states):
  - Hit: go to IDLE, no LRU update.
  - Miss: go to PF_WB if dirty, else PF_FILL.
- PF_WB / PF_FILL: same as WB / FILL with prefmux_sel=1.
  - PF_WB goes to PF_FILL; PF_FILL goes to IDLE.
  - The LRU is never updated by a prefetch, so a prefetched line remains the victim candidate.
- Handshakes:
  - pmem_read and pmem_write are held until pmem_resp and are never asserted together.
  - l2arb_mem_resp is exactly one cycle. The requester deasserts in the following cycle.
- Arbiter requests arriving during PF_* are held off: no resp, and they are served from IDLE once the prefetch completes. A memory transaction is never aborted.
- Prefetch address is prefreg+32 modulo 2^16: 0xFFE0 wraps to 0x0000.
- Simultaneous l2arb_mem_read and l2arb_mem_write: treated as a write.
- Reset in any state: IDLE on the next edge, pmem_read/pmem_write drop that cycle, no array write occurs, miss_flag=0.

Decomposition:
- lc3b_types: add l2_state_t enum {IDLE, CHECK, WB, FILL, PF_CHECK, PF_WB, PF_FILL}. The existing lc3b_2bit is reused.
- One sub-module: l2_way_decoder (2-bit way plus enable in, one-hot 4-bit out). It is instantiated for the da/ta/va/dba write-enable groups.

Test Plan:
- Read hit: line tag 0x12 valid in way 2, read 0x1240 -> l2arb_mem_resp in cycle 2, dout_sel=2, wr_lru=1, no pmem activity, then IDLE.
- Write hit: address 0x1250 in way 1 -> wr_da1=wr_dba1=1, dba_in=1, din_sel=1, one resp pulse.
- Clean read miss: read 0x3400, replace=0, not dirty -> FILL (pmem_read until resp), way-0 writes with dba_in=0, CHECK hit resp, then PF_CHECK on 0x3420 followed by PF_FILL.
- Dirty miss: replace=3, dirty=1 -> WB with addrmux_sel=1, dout_sel=3, pmem_write held across 5 stall cycles, then FILL then resp. With PREFETCH_EN=0 the FSM returns to IDLE after resp.
- Prefetch wrap and hold-off: miss at 0xFFE0 -> prefetch address 0x0000; a read asserted during PF_FILL gets no resp until IDLE, then is served.
- Reset during FILL with pmem_read=1 -> next cycle IDLE, all outputs 0, no wr_* pulse; a subsequent read of the same address misses.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types for the L2 cache controller: way index and control FSM states.
package lc3b_types;

    typedef logic [1:0] lc3b_2bit;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WB,
        FILL,
        PF_CHECK,
        PF_WB,
        PF_FILL
    } l2_state_t;

endpackage

// File: rtl/l2_way_decoder.sv
// Turns a 2-bit way index plus an enable into a one-hot per-way write strobe.
module l2_way_decoder
    import lc3b_types::*;
(
    input  lc3b_2bit   way,
    input  logic       en,
    output logic [3:0] onehot
);

    // One strobe per way; all low when the group is not being written.
    always_comb begin
        onehot = 4'b0000;
        if (en) begin
            onehot[way] = 1'b1;
        end
    end

endmodule

// File: rtl/l2_cache_control.sv
// Control FSM for the 4-way L2: lookup, dirty writeback, line fill and
// next-line prefetch. The FSM holds only the state and miss_flag; all array
// strobes and mux selects are decoded from the current state and the
// datapath status within the same cycle.
//
// Handshakes: an arbiter request (read or write level) is held until
// l2arb_mem_resp pulses for one cycle, and the requester drops it in the
// following cycle. pmem_read / pmem_write stay high until pmem_resp, are
// mutually exclusive, and are never abandoned except by reset.
module l2_cache_control
    import lc3b_types::*;
#(
    parameter bit PREFETCH_EN = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     l2arb_mem_read,
    input  logic     l2arb_mem_write,
    output logic     l2arb_mem_resp,
    output logic     pmem_read,
    output logic     pmem_write,
    input  logic     pmem_resp,
    input  logic     hit,
    input  logic     dirty,
    input  lc3b_2bit hit_num,
    input  lc3b_2bit replace,
    output logic     wr_va0,
    output logic     wr_va1,
    output logic     wr_va2,
    output logic     wr_va3,
    output logic     wr_ta0,
    output logic     wr_ta1,
    output logic     wr_ta2,
    output logic     wr_ta3,
    output logic     wr_da0,
    output logic     wr_da1,
    output logic     wr_da2,
    output logic     wr_da3,
    output logic     wr_dba0,
    output logic     wr_dba1,
    output logic     wr_dba2,
    output logic     wr_dba3,
    output logic     wr_lru,
    output logic     wr_prefreg,
    output logic     dba_in,
    output logic     prefmux_sel,
    output logic     din_sel,
    output logic     addrmux_sel,
    output lc3b_2bit dout_sel
);

    l2_state_t state_q, state_d;
    logic      miss_flag_q, miss_flag_d;

    // Group enables and the way they target (hit way on a write hit, victim on a fill).
    lc3b_2bit   way_sel;
    logic       va_en, ta_en, da_en, dba_en;
    logic [3:0] va_vec, ta_vec, da_vec, dba_vec;

    // Next state, miss tracking and all output decode; reset silences every
    // output in the cycle it is asserted so no array write or pmem access leaks.
    always_comb begin
        state_d        = state_q;
        miss_flag_d    = miss_flag_q;
        l2arb_mem_resp = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        wr_lru         = 1'b0;
        wr_prefreg     = 1'b0;
        dba_in         = 1'b0;
        prefmux_sel    = 1'b0;
        din_sel        = 1'b0;
        addrmux_sel    = 1'b0;
        dout_sel       = 2'd0;
        way_sel        = replace;
        va_en          = 1'b0;
        ta_en          = 1'b0;
        da_en          = 1'b0;
        dba_en         = 1'b0;

        case (state_q)
            IDLE: begin
                if (l2arb_mem_read || l2arb_mem_write) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (hit) begin
                    l2arb_mem_resp = 1'b1;
                    wr_lru         = 1'b1;
                    wr_prefreg     = 1'b1;
                    dout_sel       = hit_num;
                    way_sel        = hit_num;
                    // Write wins when both request lines are high.
                    if (l2arb_mem_write) begin
                        din_sel = 1'b1;
                        da_en   = 1'b1;
                        dba_en  = 1'b1;
                        dba_in  = 1'b1;
                    end
                    state_d     = (PREFETCH_EN && miss_flag_q) ? PF_CHECK : IDLE;
                    miss_flag_d = 1'b0;
                end else begin
                    miss_flag_d = 1'b1;
                    state_d     = dirty ? WB : FILL;
                end
            end
            WB, PF_WB: begin
                prefmux_sel = (state_q == PF_WB);
                addrmux_sel = 1'b1;
                dout_sel    = replace;
                pmem_write  = 1'b1;
                if (pmem_resp) begin
                    state_d = (state_q == PF_WB) ? PF_FILL : FILL;
                end
            end
            FILL, PF_FILL: begin
                prefmux_sel = (state_q == PF_FILL);
                pmem_read   = 1'b1;
                if (pmem_resp) begin
                    va_en   = 1'b1;
                    ta_en   = 1'b1;
                    da_en   = 1'b1;
                    dba_en  = 1'b1;
                    state_d = (state_q == PF_FILL) ? IDLE : CHECK;
                end
            end
            PF_CHECK: begin
                // A prefetch never touches the LRU, so the line stays the victim.
                prefmux_sel = 1'b1;
                if (hit) begin
                    state_d = IDLE;
                end else begin
                    state_d = dirty ? PF_WB : PF_FILL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            l2arb_mem_resp = 1'b0;
            pmem_read      = 1'b0;
            pmem_write     = 1'b0;
            wr_lru         = 1'b0;
            wr_prefreg     = 1'b0;
            dba_in         = 1'b0;
            prefmux_sel    = 1'b0;
            din_sel        = 1'b0;
            addrmux_sel    = 1'b0;
            dout_sel       = 2'd0;
            va_en          = 1'b0;
            ta_en          = 1'b0;
            da_en          = 1'b0;
            dba_en         = 1'b0;
        end
    end

    // State and miss_flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            miss_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_flag_q <= miss_flag_d;
        end
    end

    l2_way_decoder u_dec_va  (.way(way_sel), .en(va_en),  .onehot(va_vec));
    l2_way_decoder u_dec_ta  (.way(way_sel), .en(ta_en),  .onehot(ta_vec));
    l2_way_decoder u_dec_da  (.way(way_sel), .en(da_en),  .onehot(da_vec));
    l2_way_decoder u_dec_dba (.way(way_sel), .en(dba_en), .onehot(dba_vec));

    assign {wr_va3,  wr_va2,  wr_va1,  wr_va0}  = va_vec;
    assign {wr_ta3,  wr_ta2,  wr_ta1,  wr_ta0}  = ta_vec;
    assign {wr_da3,  wr_da2,  wr_da1,  wr_da0}  = da_vec;
    assign {wr_dba3, wr_dba2, wr_dba1, wr_dba0} = dba_vec;

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed bench for l2_cache_control: one instance with prefetch enabled,
// one with it disabled, sharing all stimulus.
module tb_l2_cache_control;

    logic clk = 1'b0;
    logic reset;
    logic rd, wr, pmem_resp, hit, dirty;
    logic [1:0] hit_num, replace;

    // Prefetch-enabled instance outputs.
    logic resp1, pr1, pw1, lru1, pref1, dbain1, pmx1, dsel1, amx1;
    logic [3:0] va1, ta1, da1, dba1;
    logic [1:0] dout1;
    // Prefetch-disabled instance outputs.
    logic resp0, pr0, pw0, lru0, pref0, dbain0, pmx0, dsel0, amx0;
    logic [3:0] va0, ta0, da0, dba0;
    logic [1:0] dout0;

    logic [26:0] outv1, outv0;
    assign outv1 = {resp1, pr1, pw1, va1, ta1, da1, dba1, lru1, pref1, dbain1, pmx1, dsel1, amx1, dout1};
    assign outv0 = {resp0, pr0, pw0, va0, ta0, da0, dba0, lru0, pref0, dbain0, pmx0, dsel0, amx0, dout0};

    logic [26:0] exp_q[$];
    int nchk = 0;
    int nerr = 0;

    localparam logic [26:0] ZERO = 27'd0;

    always #5 clk = ~clk;

    l2_cache_control #(.PREFETCH_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .l2arb_mem_read(rd), .l2arb_mem_write(wr), .l2arb_mem_resp(resp1),
        .pmem_read(pr1), .pmem_write(pw1), .pmem_resp(pmem_resp),
        .hit(hit), .dirty(dirty), .hit_num(hit_num), .replace(replace),
        .wr_va0(va1[0]), .wr_va1(va1[1]), .wr_va2(va1[2]), .wr_va3(va1[3]),
        .wr_ta0(ta1[0]), .wr_ta1(ta1[1]), .wr_ta2(ta1[2]), .wr_ta3(ta1[3]),
        .wr_da0(da1[0]), .wr_da1(da1[1]), .wr_da2(da1[2]), .wr_da3(da1[3]),
        .wr_dba0(dba1[0]), .wr_dba1(dba1[1]), .wr_dba2(dba1[2]), .wr_dba3(dba1[3]),
        .wr_lru(lru1), .wr_prefreg(pref1), .dba_in(dbain1),
        .prefmux_sel(pmx1), .din_sel(dsel1), .addrmux_sel(amx1), .dout_sel(dout1)
    );

    l2_cache_control #(.PREFETCH_EN(1'b0)) dut_nopf (
        .clk(clk), .reset(reset),
        .l2arb_mem_read(rd), .l2arb_mem_write(wr), .l2arb_mem_resp(resp0),
        .pmem_read(pr0), .pmem_write(pw0), .pmem_resp(pmem_resp),
        .hit(hit), .dirty(dirty), .hit_num(hit_num), .replace(replace),
        .wr_va0(va0[0]), .wr_va1(va0[1]), .wr_va2(va0[2]), .wr_va3(va0[3]),
        .wr_ta0(ta0[0]), .wr_ta1(ta0[1]), .wr_ta2(ta0[2]), .wr_ta3(ta0[3]),
        .wr_da0(da0[0]), .wr_da1(da0[1]), .wr_da2(da0[2]), .wr_da3(da0[3]),
        .wr_dba0(dba0[0]), .wr_dba1(dba0[1]), .wr_dba2(dba0[2]), .wr_dba3(dba0[3]),
        .wr_lru(lru0), .wr_prefreg(pref0), .dba_in(dbain0),
        .prefmux_sel(pmx0), .din_sel(dsel0), .addrmux_sel(amx0), .dout_sel(dout0)
    );

    // Expected output vector, same field order as outv1/outv0.
    function automatic logic [26:0] mk(input logic resp, input logic pr, input logic pw,
                                       input logic [3:0] va, input logic [3:0] ta,
                                       input logic [3:0] da, input logic [3:0] dba,
                                       input logic lru, input logic pref, input logic dbain,
                                       input logic pmx, input logic dsel, input logic amx,
                                       input logic [1:0] dout);
        return {resp, pr, pw, va, ta, da, dba, lru, pref, dbain, pmx, dsel, amx, dout};
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input bit sel_pf, input logic [26:0] exp);
        logic [26:0] got;
        #1;
        got = sel_pf ? outv1 : outv0;
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Waits a bounded number of cycles for a resp pulse, then pops the scoreboard.
    task automatic wait_resp(input string tag, input int max_cyc, input int exp_lat);
        int n;
        logic [26:0] e;
        n = 0;
        #1;
        while (resp1 !== 1'b1 && n < max_cyc) begin
            cyc();
            #1;
            n++;
        end
        nchk++;
        assert (resp1 === 1'b1) else begin
            nerr++;
            $error("FAIL %s_timeout got=%b exp=1", tag, resp1);
        end
        if (resp1 === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            nchk++;
            assert (outv1 === e) else begin
                nerr++;
                $error("FAIL %s_vec got=%h exp=%h", tag, outv1, e);
            end
            nchk++;
            assert (n === exp_lat) else begin
                nerr++;
                $error("FAIL %s_latency got=%0d exp=%0d", tag, n, exp_lat);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rd = 1'b0; wr = 1'b0; pmem_resp = 1'b0;
        hit = 1'b0; dirty = 1'b0; hit_num = 2'd0; replace = 2'd0;
        cyc(); cyc();
        chk("reset_out_pf", 1'b1, ZERO);
        chk("reset_out_nopf", 1'b0, ZERO);
        reset = 1'b0;
        cyc();
        chk("idle_pf", 1'b1, ZERO);
        chk("idle_nopf", 1'b0, ZERO);

        // Read hit, way 2.
        rd = 1'b1; hit = 1'b1; hit_num = 2'd2; replace = 2'd1;
        chk("t1_idle", 1'b1, ZERO);
        exp_q.push_back(mk(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 0, 0, 2'd2));
        wait_resp("t1_rd_hit", 8, 1);
        cyc(); rd = 1'b0; hit = 1'b0;
        chk("t1_back_idle", 1'b1, ZERO);

        // Write hit, way 1.
        wr = 1'b1; hit = 1'b1; hit_num = 2'd1; replace = 2'd3;
        exp_q.push_back(mk(1, 0, 0, 4'h0, 4'h0, 4'b0010, 4'b0010, 1, 1, 1, 0, 1, 0, 2'd1));
        wait_resp("t2_wr_hit", 8, 1);
        cyc(); wr = 1'b0; hit = 1'b0;
        chk("t2_back_idle", 1'b1, ZERO);

        // Read and write together behave as a write (way 3).
        rd = 1'b1; wr = 1'b1; hit = 1'b1; hit_num = 2'd3;
        exp_q.push_back(mk(1, 0, 0, 4'h0, 4'h0, 4'b1000, 4'b1000, 1, 1, 1, 0, 1, 0, 2'd3));
        wait_resp("t2b_rw_hit", 8, 1);
        cyc(); rd = 1'b0; wr = 1'b0; hit = 1'b0;
        chk("t2b_back_idle", 1'b1, ZERO);

        // Clean read miss, victim way 0, then next-line prefetch that misses clean.
        rd = 1'b1; hit = 1'b0; dirty = 1'b0; replace = 2'd0;
        cyc();
        chk("t3_check_miss", 1'b1, ZERO);
        cyc();
        chk("t3_fill", 1'b1, mk(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc();
        chk("t3_fill_hold", 1'b1, mk(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'd0));
        pmem_resp = 1'b1;
        chk("t3_fill_write", 1'b1, mk(0, 1, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc(); pmem_resp = 1'b0; hit = 1'b1; hit_num = 2'd0;
        exp_q.push_back(mk(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 0, 0, 2'd0));
        wait_resp("t3_miss_resp", 4, 0);
        cyc(); rd = 1'b0; hit = 1'b0; dirty = 1'b0;
        chk("t3_pf_check", 1'b1, mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 2'd0));
        chk("t3_nopf_idle", 1'b0, ZERO);
        cyc();
        chk("t3_pf_fill", 1'b1, mk(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 2'd0));
        cyc(); pmem_resp = 1'b1;
        chk("t3_pf_write", 1'b1, mk(0, 1, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 1, 0, 0, 2'd0));
        cyc(); pmem_resp = 1'b0;
        chk("t3_pf_done", 1'b1, ZERO);

        // Dirty miss, victim way 3, writeback stalled 5 cycles.
        rd = 1'b1; hit = 1'b0; dirty = 1'b1; replace = 2'd3;
        cyc();
        chk("t4_check_miss", 1'b1, ZERO);
        cyc();
        chk("t4_wb", 1'b1, mk(0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 2'd3));
        chk("t4_wb_nopf", 1'b0, mk(0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 2'd3));
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_wb_hold", 1'b1, mk(0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 2'd3));
        end
        cyc(); pmem_resp = 1'b1;
        chk("t4_wb_resp", 1'b1, mk(0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 2'd3));
        cyc(); pmem_resp = 1'b0; dirty = 1'b0;
        chk("t4_fill", 1'b1, mk(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc(); pmem_resp = 1'b1;
        chk("t4_fill_write", 1'b1, mk(0, 1, 0, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc(); pmem_resp = 1'b0; hit = 1'b1; hit_num = 2'd3;
        exp_q.push_back(mk(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 0, 0, 2'd3));
        wait_resp("t4_miss_resp", 4, 0);
        chk("t4_nopf_resp", 1'b0, mk(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 0, 0, 2'd3));
        cyc(); rd = 1'b0; hit = 1'b1;
        chk("t4_pf_check_hit", 1'b1, mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 2'd0));
        chk("t4_nopf_idle", 1'b0, ZERO);
        cyc(); hit = 1'b0;
        chk("t4_pf_hit_idle", 1'b1, ZERO);
        chk("t4_nopf_still_idle", 1'b0, ZERO);

        // Miss at the top line; prefetch of the wrapped line is dirty, and a
        // read arriving during the prefetch fill is held off until IDLE.
        rd = 1'b1; hit = 1'b0; dirty = 1'b0; replace = 2'd2;
        cyc();
        chk("t5_check_miss", 1'b1, ZERO);
        cyc(); pmem_resp = 1'b1;
        chk("t5_fill_write", 1'b1, mk(0, 1, 0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc(); pmem_resp = 1'b0; hit = 1'b1; hit_num = 2'd2;
        exp_q.push_back(mk(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 0, 0, 2'd2));
        wait_resp("t5_miss_resp", 4, 0);
        cyc(); rd = 1'b0; hit = 1'b0; dirty = 1'b1;
        chk("t5_pf_check", 1'b1, mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 2'd0));
        cyc();
        chk("t5_pf_wb", 1'b1, mk(0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 1, 2'd2));
        cyc(); pmem_resp = 1'b1;
        chk("t5_pf_wb_resp", 1'b1, mk(0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 1, 2'd2));
        cyc(); pmem_resp = 1'b0; dirty = 1'b0; rd = 1'b1;
        chk("t5_pf_fill_holdoff", 1'b1, mk(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 2'd0));
        cyc();
        chk("t5_pf_fill_holdoff2", 1'b1, mk(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 2'd0));
        cyc(); pmem_resp = 1'b1;
        chk("t5_pf_write", 1'b1, mk(0, 1, 0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 0, 0, 0, 1, 0, 0, 2'd0));
        cyc(); pmem_resp = 1'b0; hit = 1'b1; hit_num = 2'd1;
        chk("t5_idle_no_resp", 1'b1, ZERO);
        exp_q.push_back(mk(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 0, 0, 2'd1));
        wait_resp("t5_held_read", 4, 1);
        cyc(); rd = 1'b0; hit = 1'b0;
        chk("t5_back_idle", 1'b1, ZERO);

        // Reset in the middle of a fill.
        rd = 1'b1; hit = 1'b0; dirty = 1'b0; replace = 2'd1;
        cyc();
        chk("t6_check_miss", 1'b1, ZERO);
        cyc();
        chk("t6_fill", 1'b1, mk(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc(); reset = 1'b1; pmem_resp = 1'b1;
        chk("t6_reset_drop", 1'b1, ZERO);
        cyc(); reset = 1'b0; pmem_resp = 1'b0; rd = 1'b0;
        chk("t6_after_reset", 1'b1, ZERO);
        chk("t6_after_reset_nopf", 1'b0, ZERO);
        // A hit right after reset must not start a prefetch (miss_flag cleared).
        rd = 1'b1; hit = 1'b1; hit_num = 2'd0;
        exp_q.push_back(mk(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 0, 0, 2'd0));
        wait_resp("t6_hit_after_reset", 4, 1);
        cyc(); rd = 1'b0; hit = 1'b0;
        chk("t6_no_prefetch", 1'b1, ZERO);
        // The line never got written, so reading it again misses into a fill.
        rd = 1'b1;
        cyc();
        chk("t6_remiss_check", 1'b1, ZERO);
        cyc();
        chk("t6_refill", 1'b1, mk(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'd0));

        nchk++;
        assert (exp_q.size() == 0) else begin
            nerr++;
            $error("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
